// File: rtl/alu_serial_nbit.sv
// Bit-serial WIDTH-bit ALU: ADD/SUB/CMP/AND, one bit per clock, LSB first, start/done handshake.
// Optional macro ALU_SERIAL_SUB_EN enables true subtract for mode 01; otherwise mode 01 runs as ADD.
module alu_serial_nbit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             n,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, f_q, f_d;
  logic [1:0]       mode_q, mode_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             c_q, c_d, cgt_q, cgt_d, clt_q, clt_d;
  logic             cout_q, cout_d, n_q, n_d, eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;

  logic ai, bi, bx, sum, carry, res, cgt_nx, clt_nx;

  always_comb begin
    ai = a_q[0];
    bi = b_q[0];
`ifdef ALU_SERIAL_SUB_EN
    bx = (mode_q == 2'b01) ? ~bi : bi;
`else
    bx = bi;
`endif
    sum   = ai ^ bx ^ c_q;
    carry = (ai & bx) | (ai & c_q) | (bx & c_q);

    case (mode_q)
      2'b10:   res = 1'b0;
      2'b11:   res = ai & bi;
      default: res = sum;
    endcase

    // LSB first: a later (more significant) differing bit overrides earlier ones
    cgt_nx = cgt_q;
    clt_nx = clt_q;
    if (ai & ~bi) begin
      cgt_nx = 1'b1;
      clt_nx = 1'b0;
    end else if (~ai & bi) begin
      cgt_nx = 1'b0;
      clt_nx = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cgt_d   = cgt_q;
    clt_d   = clt_q;
    f_d     = f_q;
    cout_d  = cout_q;
    n_d     = n_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d    = a;
          b_d    = b;
          mode_d = mode;
          cnt_d  = '0;
`ifdef ALU_SERIAL_SUB_EN
          c_d    = (mode == 2'b01) ? 1'b1 : cin;
`else
          c_d    = cin;
`endif
          cgt_d  = 1'b0;
          clt_d  = 1'b0;
          cout_d = 1'b0;
          n_d    = 1'b0;
          eq_d   = 1'b0;
          gt_d   = 1'b0;
          lt_d   = 1'b0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        f_d   = {res, f_q[WIDTH-1:1]};
        c_d   = carry;
        cgt_d = cgt_nx;
        clt_d = clt_nx;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          cnt_d   = '0;
          case (mode_q)
            2'b10: begin
              eq_d = ~cgt_nx & ~clt_nx;
              gt_d = cgt_nx;
              lt_d = clt_nx;
            end
            2'b11: ;
            default: begin
              cout_d = carry;
              n_d    = res;
            end
          endcase
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cgt_q   <= 1'b0;
      clt_q   <= 1'b0;
      f_q     <= '0;
      cout_q  <= 1'b0;
      n_q     <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cgt_q   <= cgt_d;
      clt_q   <= clt_d;
      f_q     <= f_d;
      cout_q  <= cout_d;
      n_q     <= n_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign f    = f_q;
  assign cout = cout_q;
  assign n    = n_q;
  assign eq   = eq_q;
  assign gt   = gt_q;
  assign lt   = lt_q;

endmodule

// File: tb/tb_alu_serial_nbit.sv
// Testbench for alu_serial_nbit (WIDTH=4): directed plan scenarios plus randomized operations
// against an arithmetic reference model; honours ALU_SERIAL_SUB_EN if defined.
module tb_alu_serial_nbit;
  localparam int unsigned W = 4;
  localparam logic [W-1:0] Mask = '1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic cin = 1'b0;
  logic [1:0] mode = 2'b00;
  logic busy, done, cout, n, eq, gt, lt;
  logic [W-1:0] f;

  int compared = 0;
  int mismatched = 0;

  logic [W-1:0] exp_f;
  logic exp_cout, exp_n, exp_eq, exp_gt, exp_lt;

  alu_serial_nbit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .mode(mode),
    .busy(busy), .done(done), .f(f), .cout(cout), .n(n), .eq(eq), .gt(gt), .lt(lt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference model from plain arithmetic on whole operands.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                       input logic [1:0] mm);
    logic [W:0] s;
    exp_f = '0; exp_cout = 0; exp_n = 0; exp_eq = 0; exp_gt = 0; exp_lt = 0;
    case (mm)
      2'b00: begin
        s = {1'b0, ma} + {1'b0, mb} + (W+1)'(mc);
        exp_f = s[W-1:0]; exp_cout = s[W]; exp_n = s[W-1];
      end
      2'b01: begin
`ifdef ALU_SERIAL_SUB_EN
        exp_f = (ma - mb) & Mask; exp_cout = (ma >= mb); exp_n = exp_f[W-1];
`else
        s = {1'b0, ma} + {1'b0, mb} + (W+1)'(mc);
        exp_f = s[W-1:0]; exp_cout = s[W]; exp_n = s[W-1];
`endif
      end
      2'b10: begin
        exp_eq = (ma == mb); exp_gt = (ma > mb); exp_lt = (ma < mb);
      end
      default: exp_f = ma & mb;
    endcase
  endtask

  task automatic check_results(input string tag);
    chk({tag, ".f"}, 32'(f), 32'(exp_f));
    chk({tag, ".cout"}, 32'(cout), 32'(exp_cout));
    chk({tag, ".n"}, 32'(n), 32'(exp_n));
    chk({tag, ".flags"}, {29'd0, eq, gt, lt}, {29'd0, exp_eq, exp_gt, exp_lt});
  endtask

  // Drives start before the next edge (E0) and checks the RUN entry state.
  task automatic launch(input logic [W-1:0] la, input logic [W-1:0] lb, input logic lc,
                        input logic [1:0] lm);
    @(negedge clk);
    start = 1'b1; a = la; b = lb; cin = lc; mode = lm;
    model(la, lb, lc, lm);
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; cin = $urandom; mode = $urandom;
    chk("e0.busy_done", {30'd0, busy, done}, 32'b10);
    chk("e0.flags_zero", {27'd0, cout, n, eq, gt, lt}, 32'd0);
  endtask

  // Walks E1..E(W); optional ignored start pulse during RUN.
  task automatic finish_op(input string tag, input bit poke);
    for (int k = 1; k < W; k++) begin
      if (poke && k == 1) begin
        start = 1'b1; a = $urandom; b = $urandom; mode = $urandom;
      end
      if (poke && k == W - 1) start = 1'b0;
      @(posedge clk); #1;
      chk({tag, ".run"}, {30'd0, busy, done}, 32'b10);
    end
    @(posedge clk); #1;
    chk({tag, ".done"}, {30'd0, busy, done}, 32'b01);
    check_results(tag);
  endtask

  initial begin
    #1;
    chk("reset.ctl", {30'd0, busy, done}, 32'd0);
    chk("reset.out", {23'd0, f, cout, n, eq, gt, lt}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    launch(4'd9, 4'd8, 1'b0, 2'b00); finish_op("add_9_8", 0);
    launch(4'd9, 4'd8, 1'b1, 2'b00); finish_op("add_9_8_c", 0);
    launch(4'd3, 4'd5, 1'b0, 2'b01); finish_op("sub_3_5", 0);
    launch(4'd5, 4'd5, 1'b0, 2'b01); finish_op("sub_5_5", 0);
    launch(4'd6, 4'd9, 1'b0, 2'b10); finish_op("cmp_lt", 0);
    launch(4'd9, 4'd6, 1'b0, 2'b10); finish_op("cmp_gt", 0);
    launch(4'hA, 4'hA, 1'b1, 2'b10); finish_op("cmp_eq", 0);
    launch(4'hC, 4'hA, 1'b1, 2'b11); finish_op("and_c_a", 0);

    // Outputs hold through idle cycles.
    repeat (3) @(posedge clk);
    #1;
    chk("hold.ctl", {30'd0, busy, done}, 32'd0);
    check_results("hold");

    // Start pulse inside RUN must not create another operation.
    launch(4'd7, 4'd6, 1'b1, 2'b00); finish_op("poke", 1);
    @(posedge clk); #1;
    chk("poke.no_extra", {30'd0, busy, done}, 32'd0);
    repeat (W) @(posedge clk);
    #1;
    chk("poke.still_idle", {30'd0, busy, done}, 32'd0);

    // Back-to-back: second start in DONE; second done lands W+1 edges later.
    launch(4'd2, 4'd3, 1'b0, 2'b00); finish_op("b2b_1", 0);
    launch(4'd14, 4'd3, 1'b0, 2'b10); finish_op("b2b_2", 0);

    // Asynchronous reset mid-RUN.
    launch(4'd15, 4'd1, 1'b0, 2'b00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_run.ctl", {30'd0, busy, done}, 32'd0);
    chk("rst_run.out", {23'd0, f, cout, n, eq, gt, lt}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_run.no_done", {30'd0, busy, done}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    launch(4'd11, 4'd7, 1'b1, 2'b00); finish_op("after_rst", 0);

    for (int i = 0; i < 24; i++) begin
      launch(W'($urandom), W'($urandom), 1'($urandom), 2'($urandom));
      finish_op("rand", 0);
      if ($urandom_range(1, 0) == 1) repeat ($urandom_range(3, 1)) @(posedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_serial_nbit.md
# alu_serial_nbit

Parametrised bit-serial ALU that reuses a single 1-bit datapath slice to perform WIDTH-bit add, subtract, unsigned compare and bitwise AND, one bit per clock, LSB first. It is the multi-bit successor of the team's combinational 1-bit ALU slice. It sits between the operand registers and the result bus, with a start/done handshake to the sequencing FSM. The carry, borrow and compare chain is held in flops instead of being rippled combinationally.

## Interface
- WIDTH, 4, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when not busy.
- a  input  WIDTH  operand A, captured on the accepting edge.
- b  input  WIDTH  operand B, captured on the accepting edge.
- cin  input  1  carry-in for ADD, captured on the accepting edge.
- mode  input  2  00 ADD, 01 SUB, 10 CMP, 11 AND; captured on the accepting edge.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; results are valid.
- f  output  WIDTH  arithmetic/logic result.
- cout  output  1  ADD: carry out; SUB: 1 = no borrow (A >= B).
- n  output  1  f[WIDTH-1] for ADD/SUB, else 0.
- eq, gt, lt  output  1 each  CMP flags (unsigned A vs B); 0 in other modes.

## Operation
- FSM states are IDLE, RUN and DONE. Reset puts the FSM in IDLE.
- IDLE or DONE, with start=1:
  - latch a, b, mode and cin into shift/holding registers;
  - clear the bit counter;
  - preset the chain register: ADD = cin, SUB = 1, CMP = eq-so-far 1 with gt=lt=0;
  - go to RUN.
- RUN, each cycle, operate on bit i = counter, from the LSB of the shift registers:
  - ADD: sum = ai^bi^c; c = majority(ai,bi,c).
  - SUB: the same equations with bi replaced by ~bi, so A + ~B + 1; cin is ignored.
  - CMP: if ai&~bi then gt=1, lt=0; if ~ai&bi then lt=1, gt=0; if equal, hold. Because processing is LSB first, the last differing bit (the most significant) wins.
  - AND: result bit = ai&bi.
  - The result bit is shifted into f from the MSB end. Operands shift right. The counter increments.
- When counter == WIDTH-1 and that bit is processed: go to DONE and update cout, n and the flags.
  - eq = ~gt & ~lt.
  - In AND mode, cout = 0.
- DONE lasts one cycle with done=1, then goes to IDLE unless start is accepted.
- f, cout, n, eq, gt and lt hold their values from DONE until the next accepted start.
  - During RUN, f shows partial shift contents and is not valid.
  - Flags read 0 during RUN.
- start while in RUN is ignored. It is not queued.
- The mode, a, b and cin inputs are don't-care except on the accepting edge.

## Timing
- Reset: busy=0, done=0, f=0, cout=0, n=0, eq=0, gt=0, lt=0, counter=0. The FSM goes to IDLE immediately, without waiting for a clock.
- Reset during RUN aborts the operation; no done pulse is produced.
- Let edge E0 be the edge that accepts start.
  - busy=1 from E0 to E(WIDTH).
  - done=1 and results are valid from E(WIDTH) to E(WIDTH+1).
  - Latency is WIDTH+1 cycles from the start edge to the end of done.
- Back-to-back: start=1 during DONE is accepted at E(WIDTH+1). busy rises on that edge and done falls on it.
  - Throughput is one operation per WIDTH+1 cycles.
- The counter is $clog2(WIDTH) bits wide. It never wraps during a valid operation.

## Configuration
- ALU_SERIAL_SUB_EN defined: mode 01 performs SUB as described above.
- ALU_SERIAL_SUB_EN not defined: the B-inversion logic and forced carry are not compiled in.
  - Mode 01 executes as ADD (cin is used, cout is the carry).
  - All other modes and all timing are unchanged.

## Test plan
All scenarios use WIDTH=4.
- ADD, a=9, b=8, cin=0, start at E0 → done exactly at E4; f=1, cout=1, n=0. Repeat with cin=1 → f=2.
- SUB (macro defined), a=3, b=5 → f=4'hE, cout=0, n=1. a=5, b=5 → f=0, cout=1. With the macro undefined, a=3, b=5 → f=8, cout=0.
- CMP: a=6, b=9 → lt=1, gt=0, eq=0. a=9, b=6 → gt=1. a=b=4'hA → eq=1. In every case f=0 and n=0.
- AND, a=4'hC, b=4'hA → f=4'h8, cout=0. The next start captures new operands, and the outputs hold until then.
- Start pulses during RUN are ignored (no extra done). Back-to-back start in DONE → the second done occurs 5 cycles after the first.
- Assert rst_n=0 mid-RUN (after E2) → all outputs are 0 immediately. No done appears. A new start after reset release completes normally.
